// File: rtl/m_time_set_ctrl.sv
// Time-setting mode controller: sequences RUN / SET_HOUR / SET_MIN and produces the
// minute/hour increment pulses, auto-repeat, inactivity timeout and display blink.
module m_time_set_ctrl #(
   parameter int unsigned REPEAT_DLY = 16,
   parameter int unsigned REPEAT_PER = 4,
   parameter int unsigned TIMEOUT_S  = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic       run_en,
   output logic       inc_hour,
   output logic       inc_min,
   output logic       clr_sec,
   output logic [1:0] field_sel,
   output logic       blink
);

   localparam int unsigned IW = $clog2(TIMEOUT_S + 1);
   localparam int unsigned RW = $clog2(REPEAT_DLY + REPEAT_PER + 1);

   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_S - 1);
   localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DLY);
   localparam logic [RW-1:0] REP_WRAP  = RW'(REPEAT_DLY + REPEAT_PER);
   localparam logic [RW-1:0] REP_AFTER = RW'(REPEAT_DLY + 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] idle_q, idle_d;
   logic [RW-1:0] rep_q, rep_d;
   logic          btn_inc_q;
   logic          phase_q, phase_d;
   logic          run_en_q, run_en_d;
   logic          inc_hour_q, inc_hour_d;
   logic          inc_min_q, inc_min_d;
   logic          clr_sec_q, clr_sec_d;
   logic [1:0]    field_sel_q, field_sel_d;
   logic          blink_q, blink_d;

   logic in_set, rise, rep_fire, fire, state_chg;

   always_comb begin
      state_d     = state_q;
      idle_d      = idle_q;
      rep_d       = rep_q;
      phase_d     = phase_q;
      inc_hour_d  = 1'b0;
      inc_min_d   = 1'b0;

      in_set   = (state_q != RUN);
      rise     = btn_inc & ~btn_inc_q;
      rep_fire = in_set & btn_inc & ((rep_q == REP_FIRST) | (rep_q == REP_WRAP));
      // A mode press in the same cycle swallows any increment.
      fire     = in_set & ~btn_mode & (rise | rep_fire);

      if (btn_mode) begin
         case (state_q)
            RUN:      state_d = SET_HOUR;
            SET_HOUR: state_d = SET_MIN;
            SET_MIN:  state_d = RUN;
            default:  state_d = RUN;
         endcase
      end else if (in_set && !fire && tick_1hz && (idle_q == IDLE_LAST)) begin
         state_d = RUN;
      end else begin
         state_d = state_q;
      end
      state_chg = (state_d != state_q);

      if (!in_set || btn_mode || fire || state_chg) begin
         idle_d = {IW{1'b0}};
      end else if (tick_1hz) begin
         idle_d = idle_q + {{(IW-1){1'b0}}, 1'b1};
      end else begin
         idle_d = idle_q;
      end

      // rep_q = cycles since the press edge; zero means no repeat window is open.
      if (!in_set || !btn_inc || btn_mode || state_chg) begin
         rep_d = {RW{1'b0}};
      end else if (rise) begin
         rep_d = {{(RW-1){1'b0}}, 1'b1};
      end else if (rep_q == {RW{1'b0}}) begin
         rep_d = {RW{1'b0}};
      end else if (rep_q == REP_WRAP) begin
         rep_d = REP_AFTER;
      end else begin
         rep_d = rep_q + {{(RW-1){1'b0}}, 1'b1};
      end

      if ((state_d == RUN) || state_chg) begin
         phase_d = 1'b0;
      end else if (tick_1hz) begin
         phase_d = ~phase_q;
      end else begin
         phase_d = phase_q;
      end

      inc_hour_d  = fire & (state_q == SET_HOUR);
      inc_min_d   = fire & (state_q == SET_MIN);
      run_en_d    = (state_d == RUN);
      clr_sec_d   = in_set & (state_d == RUN);
      field_sel_d = state_d;
      // Blank is suppressed for one cycle after an increment so the new value shows.
      blink_d     = phase_d & ~(inc_hour_q | inc_min_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         idle_q      <= {IW{1'b0}};
         rep_q       <= {RW{1'b0}};
         btn_inc_q   <= 1'b0;
         phase_q     <= 1'b0;
         run_en_q    <= 1'b1;
         inc_hour_q  <= 1'b0;
         inc_min_q   <= 1'b0;
         clr_sec_q   <= 1'b0;
         field_sel_q <= 2'd0;
         blink_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         idle_q      <= idle_d;
         rep_q       <= rep_d;
         btn_inc_q   <= btn_inc;
         phase_q     <= phase_d;
         run_en_q    <= run_en_d;
         inc_hour_q  <= inc_hour_d;
         inc_min_q   <= inc_min_d;
         clr_sec_q   <= clr_sec_d;
         field_sel_q <= field_sel_d;
         blink_q     <= blink_d;
      end
   end

   assign run_en    = run_en_q;
   assign inc_hour  = inc_hour_q;
   assign inc_min   = inc_min_q;
   assign clr_sec   = clr_sec_q;
   assign field_sel = field_sel_q;
   assign blink     = blink_q;

endmodule

// File: tb/tb_m_time_set_ctrl.sv
// Scoreboard bench for m_time_set_ctrl: directed scenarios plus random stimulus,
// expected outputs from a cycle-level behavioural model, checked by a separate monitor.
module tb_m_time_set_ctrl;

   localparam int DLY = 16;
   localparam int PER = 4;
   localparam int TO  = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_1hz = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic       run_en, inc_hour, inc_min, clr_sec, blink;
   logic [1:0] field_sel;

   m_time_set_ctrl #(.REPEAT_DLY(DLY), .REPEAT_PER(PER), .TIMEOUT_S(TO)) dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .run_en(run_en), .inc_hour(inc_hour), .inc_min(inc_min), .clr_sec(clr_sec),
      .field_sel(field_sel), .blink(blink)
   );

   always #5 clk = ~clk;

   // Expected output vector {run_en, inc_hour, inc_min, clr_sec, field_sel, blink}
   logic [6:0] exp_q[$];
   int total = 0;
   int bad   = 0;
   int cyc_n = 0;

   // Model state: field (0 run, 1 hour, 2 minute), seconds idle, cycles since press.
   int m_field = 0;
   int m_idle  = 0;
   int m_age   = -1;
   bit m_phase = 1'b0;
   bit m_last_inc = 1'b0;
   bit m_btn_prev = 1'b0;

   function automatic logic [6:0] model(input bit m, input bit inc, input bit t, input bit r);
      int  nf;
      bit  fire, ih, im, clr, bl;
      if (r) begin
         m_field = 0; m_idle = 0; m_age = -1; m_phase = 0; m_last_inc = 0; m_btn_prev = 0;
         return {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
      end
      if (inc && m_field != 0)
         m_age = (!m_btn_prev) ? 0 : ((m_age >= 0) ? m_age + 1 : -1);
      else
         m_age = -1;
      fire = (m_field != 0) && (m_age >= 0) &&
             (m_age == 0 || (m_age >= DLY && ((m_age - DLY) % PER) == 0));
      if (m) begin
         fire  = 0;
         m_age = -1;
      end
      nf = m_field;
      if (m) nf = (m_field + 1) % 3;
      else if (m_field != 0 && !fire && t) begin
         m_idle++;
         if (m_idle == TO) nf = 0;
      end
      if (m || fire || nf != m_field || m_field == 0) m_idle = 0;
      clr = (m_field != 0) && (nf == 0);
      if (nf != m_field) m_age = -1;
      if (nf == 0 || nf != m_field) m_phase = 0;
      else if (t) m_phase = ~m_phase;
      ih = fire && (m_field == 1);
      im = fire && (m_field == 2);
      bl = m_phase && !m_last_inc;
      m_last_inc = ih | im;
      m_field = nf;
      m_btn_prev = inc;
      return {(nf == 0), ih, im, clr, 2'(nf), bl};
   endfunction

   task automatic cyc(input bit m, input bit inc, input bit t, input bit r);
      rst = r; btn_mode = m; btn_inc = inc; tick_1hz = t;
      @(posedge clk);
      exp_q.push_back(model(m, inc, t, r));
      #2;
      btn_mode = 1'b0; tick_1hz = 1'b0;
   endtask

   task automatic idle_n(input int n, input bit inc);
      for (int k = 0; k < n; k++) cyc(1'b0, inc, 1'b0, 1'b0);
   endtask

   // Monitor: compare DUT outputs against the queued expectation each cycle.
   always @(posedge clk) begin
      logic [6:0] act, e;
      #1;
      cyc_n++;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         act = {run_en, inc_hour, inc_min, clr_sec, field_sel, blink};
         total++;
         if (act !== e) begin
            bad++;
            $display("FAIL outputs cyc=%0d act{run,ih,im,clr,fs,bl}=%b required=%b", cyc_n, act, e);
         end
      end
   end

   initial begin
      bit inc_lvl;
      // Reset, then 20 idle cycles.
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      idle_n(20, 1'b0);
      // SET_HOUR, single-cycle press.
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      idle_n(2, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle_n(5, 1'b0);
      // SET_MIN, hold 30 cycles for auto-repeat, then release.
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      idle_n(2, 1'b0);
      idle_n(30, 1'b1);
      idle_n(12, 1'b0);
      // Back to RUN with clr_sec.
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      idle_n(3, 1'b0);
      // SET_HOUR then 10 ticks for the timeout.
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < TO; k++) begin
         idle_n(3, 1'b0);
         cyc(1'b0, 1'b0, 1'b1, 1'b0);
      end
      idle_n(3, 1'b0);
      // Mode press coincident with an inc edge in SET_HOUR; hold stays silent in SET_MIN.
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      idle_n(2, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      idle_n(25, 1'b1);
      idle_n(2, 1'b0);
      // Reset in the middle of a held repeat.
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle_n(18, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      idle_n(3, 1'b0);
      // Random traffic.
      inc_lvl = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 19) == 0) inc_lvl = ~inc_lvl;
         cyc(($urandom_range(0, 39) == 0), inc_lvl, ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 799) == 0));
      end
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
